// File: rtl/point_pkg.sv
// Shared types and constants for the four-digit BCD point counter.
package point_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t        BCD_MAX    = 4'd9;
  localparam bcd_t        BCD_MIN    = 4'd0;
  localparam int unsigned NUM_DIGITS = 4;

  // Bit positions of the buttons inside the packed synchronizer vectors.
  localparam int unsigned BTN_INC  = 0;
  localparam int unsigned BTN_DEC  = 1;
  localparam int unsigned BTN_CLR  = 2;
  localparam int unsigned NUM_BTNS = 3;

endpackage

// File: rtl/bcd_digit.sv
// One registered BCD digit with ripple carry-out and borrow-out for chaining.
module bcd_digit
  import point_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cin,
  input  logic bin,
  output bcd_t digit,
  output logic cout,
  output logic bout
);

  bcd_t digit_q, digit_d;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (cin) begin
      digit_d = (digit_q == BCD_MAX) ? BCD_MIN : digit_q + 4'd1;
    end else if (bin) begin
      digit_d = (digit_q == BCD_MIN) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;
  assign cout  = (digit_q == BCD_MAX) & cin;
  assign bout  = (digit_q == BCD_MIN) & bin;

endmodule

// File: rtl/point_counter.sv
// Four-digit BCD score counter driven by synchronized, edge-detected buttons.
// Define SCORE_WRAP_EN to wrap 9999<->0000 instead of saturating.
module point_counter
  import point_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic       btn_clr,
  output logic [3:0] score00,
  output logic [3:0] score01,
  output logic [3:0] score02,
  output logic [3:0] score03,
  output logic       at_max,
  output logic       at_zero
);

  logic [NUM_BTNS-1:0]                    btn_raw;
  logic [SYNC_STAGES-1:0][NUM_BTNS-1:0]   sync_q, sync_d;
  logic [NUM_BTNS-1:0]                    prev_q, prev_d;
  logic [NUM_BTNS-1:0]                    evt;

  assign btn_raw = {btn_clr, btn_dec, btn_inc};

  always_comb begin
    sync_d[0] = btn_raw;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    evt    = sync_q[SYNC_STAGES-1] & ~prev_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  logic clr_go, inc_go, dec_go;
  logic [NUM_DIGITS:0] carry, borrow;
  bcd_t digit [NUM_DIGITS];

  // Simultaneous inc and dec cancel; clear overrides both.
  always_comb begin
    clr_go = evt[BTN_CLR];
    inc_go = evt[BTN_INC] & ~evt[BTN_DEC] & ~clr_go;
    dec_go = evt[BTN_DEC] & ~evt[BTN_INC] & ~clr_go;
`ifdef SCORE_WRAP_EN
    carry[0]  = inc_go;
    borrow[0] = dec_go;
`else
    carry[0]  = inc_go & ~at_max;
    borrow[0] = dec_go & ~at_zero;
`endif
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr_go),
      .cin   (carry[g]),
      .bin   (borrow[g]),
      .digit (digit[g]),
      .cout  (carry[g+1]),
      .bout  (borrow[g+1])
    );
  end

  // Chain outputs past the thousands digit only matter as wrap indicators.
  logic unused_chain_out;
  assign unused_chain_out = carry[NUM_DIGITS] | borrow[NUM_DIGITS];

  always_comb begin
    at_max  = 1'b1;
    at_zero = 1'b1;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      at_max  = at_max  & (digit[i] == BCD_MAX);
      at_zero = at_zero & (digit[i] == BCD_MIN);
    end
  end

  assign score00 = digit[0];
  assign score01 = digit[1];
  assign score02 = digit[2];
  assign score03 = digit[3];

endmodule

// File: tb/tb_point_counter.sv
// Scoreboard bench for point_counter: directed presses queue expected scores.
module tb_point_counter;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b1;
  logic       btn_inc = 1'b0;
  logic       btn_dec = 1'b0;
  logic       btn_clr = 1'b0;
  logic [3:0] score00, score01, score02, score03;
  logic       at_max, at_zero;
  logic [15:0] score_w;

  always #5 clk = ~clk;

  point_counter #(.SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_inc (btn_inc),
    .btn_dec (btn_dec),
    .btn_clr (btn_clr),
    .score00 (score00),
    .score01 (score01),
    .score02 (score02),
    .score03 (score03),
    .at_max  (at_max),
    .at_zero (at_zero)
  );

  assign score_w = {score03, score02, score01, score00};

  typedef struct {
    string       name;
    logic [15:0] score;
    logic        mx;
    logic        zr;
  } exp_t;

  exp_t        exp_q[$];
  event        chk_ev;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [2:0] P_INC = 3'b001;
  localparam logic [2:0] P_DEC = 3'b010;
  localparam logic [2:0] P_CLR = 3'b100;

  // Monitor: digit range every falling edge, plus any queued expectation.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk or chk_ev);
      checks++;
      assert (score00 <= 4'd9 && score01 <= 4'd9 && score02 <= 4'd9 && score03 <= 4'd9)
      else begin
        $display("FAIL digit_range: score=%h required every digit <= 9", score_w);
        errors++;
      end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (score_w !== e.score || at_max !== e.mx || at_zero !== e.zr) begin
          $display("FAIL %s: got score=%h at_max=%b at_zero=%b required score=%h at_max=%b at_zero=%b",
                   e.name, score_w, at_max, at_zero, e.score, e.mx, e.zr);
          errors++;
        end
      end
    end
  end

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] which, input int unsigned n);
    repeat (n) begin
      {btn_clr, btn_dec, btn_inc} = which;
      tick(2);
      {btn_clr, btn_dec, btn_inc} = 3'b000;
      tick(2);
    end
  endtask

  task automatic expect_s(input string name, input logic [15:0] s, input logic mx, input logic zr);
    exp_t e;
    e.name  = name;
    e.score = s;
    e.mx    = mx;
    e.zr    = zr;
    exp_q.push_back(e);
    -> chk_ev;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    expect_s("reset", 16'h0000, 1'b0, 1'b1);
    rst_n = 1'b1;
    tick(2);

    press(P_INC, 1);
    expect_s("first_inc", 16'h0001, 1'b0, 1'b0);
    press(P_INC, 11);
    expect_s("twelve_inc", 16'h0012, 1'b0, 1'b0);

    press(P_CLR, 1);
    expect_s("clear", 16'h0000, 1'b0, 1'b1);
    press(P_INC, 99);
    expect_s("preload_0099", 16'h0099, 1'b0, 1'b0);
    press(P_INC, 1);
    expect_s("carry_0100", 16'h0100, 1'b0, 1'b0);
    press(P_DEC, 1);
    expect_s("borrow_0099", 16'h0099, 1'b0, 1'b0);
    btn_dec = 1'b1;
    tick(50);
    btn_dec = 1'b0;
    tick(3);
    expect_s("hold_dec_once", 16'h0098, 1'b0, 1'b0);

    press(P_CLR, 1);
    press(P_DEC, 1);
`ifdef SCORE_WRAP_EN
    expect_s("dec_at_zero", 16'h9999, 1'b1, 1'b0);
    press(P_INC, 1);
    expect_s("inc_at_max", 16'h0000, 1'b0, 1'b1);
`else
    expect_s("dec_at_zero", 16'h0000, 1'b0, 1'b1);
    press(P_INC, 9999);
    expect_s("reach_9999", 16'h9999, 1'b1, 1'b0);
    press(P_INC, 1);
    expect_s("inc_at_max", 16'h9999, 1'b1, 1'b0);
`endif

    press(P_CLR, 1);
    press(P_INC, 42);
    expect_s("preload_0042", 16'h0042, 1'b0, 1'b0);
    press(P_INC | P_DEC, 1);
    expect_s("inc_dec_same", 16'h0042, 1'b0, 1'b0);
    press(P_CLR | P_INC, 1);
    expect_s("clr_inc_same", 16'h0000, 1'b0, 1'b1);

    press(P_INC, 357);
    expect_s("preload_0357", 16'h0357, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 expect_s("async_reset", 16'h0000, 1'b0, 1'b1);
    tick(2);
    rst_n = 1'b1;
    tick(8);
    expect_s("no_spurious", 16'h0000, 1'b0, 1'b1);

    rst_n   = 1'b0;
    btn_inc = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(8);
    expect_s("held_through_reset", 16'h0001, 1'b0, 1'b0);
    tick(20);
    btn_inc = 1'b0;
    tick(3);
    expect_s("held_single_event", 16'h0001, 1'b0, 1'b0);

    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
